// File: rtl/vector_fetch_decode.sv
// vector_fetch_decode: a multi-cycle fetch/decode front end for a vector processor.
// Each instruction takes three cycles: FETCH drives the instruction-memory read,
// WAIT captures the returned word and its scalar-register operands, and ISSUE
// presents the decoded fields downstream.
// LDI writes the scalar file at its ISSUE edge. That edge comes before the next
// instruction's WAIT edge, so the next instruction sees the new value without
// any forwarding path.
module vector_fetch_decode #(
    parameter int PC_WIDTH  = 8,
    parameter int NUM_SREGS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    output logic                imem_en,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [4:0]          ID_OP,
    output logic [4:0]          ID_VD,
    output logic [4:0]          ID_VS,
    output logic [4:0]          ID_VT,
    output logic [11:0]         ID_SHAMT,
    output logic [15:0]         ID_IMM16,
    output logic [31:0]         register_mov_data,
    output logic [31:0]         data_memory_direction,
    output logic                ID_VALID,
    output logic                busy,
    output logic                halted,
    output logic [PC_WIDTH-1:0] pc
);

    localparam int         SIDX_W  = (NUM_SREGS > 1) ? $clog2(NUM_SREGS) : 1;
    localparam logic [4:0] OP_LDI  = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [31:0]         instr_q;
    logic [31:0]         mov_q;
    logic [31:0]         dmd_q;
    logic [31:0]         sreg_q [NUM_SREGS];

    // Operand read uses the word arriving from memory, so it can be captured at the WAIT edge.
    logic [SIDX_W-1:0]   vs_idx;
    logic [31:0]         vs_val;
    logic [31:0]         rdata_imm_sext;

    // LDI write port, driven from the instruction held during ISSUE.
    logic [4:0]          op;
    logic [SIDX_W-1:0]   ldi_idx;
    logic [31:0]         ldi_val;
    logic                ldi_we;

    assign vs_idx         = imem_rdata[17 +: SIDX_W];
    assign vs_val         = sreg_q[vs_idx];
    assign rdata_imm_sext = {{16{imem_rdata[15]}}, imem_rdata[15:0]};

    assign op      = instr_q[31:27];
    assign ldi_idx = instr_q[22 +: SIDX_W];
    assign ldi_val = {{16{instr_q[15]}}, instr_q[15:0]};
    assign ldi_we  = (state_q == S_ISSUE) && (op == OP_LDI);

    // Scalar register file. Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SREGS; i++) begin
                sreg_q[i] <= '0;
            end
        end else if (ldi_we && (ldi_idx != '0)) begin
            sreg_q[ldi_idx] <= ldi_val;
        end
    end

    // Sequencer: the FSM, the program counter, the instruction register and the operand registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            mov_q   <= '0;
            dmd_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q    <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    instr_q <= imem_rdata;
                    mov_q   <= vs_val;
                    dmd_q   <= vs_val + rdata_imm_sext;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (op == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if ((op == OP_LDI) || !stall) begin
                        // The pc wraps naturally at 2^PC_WIDTH.
                        pc_q    <= pc_q + PC_WIDTH'(1);
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_en               = (state_q == S_FETCH);
    assign imem_addr             = pc_q;
    assign pc                    = pc_q;
    assign busy                  = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign halted                = (state_q == S_HALT);
    assign ID_VALID              = (state_q == S_ISSUE) && (op != OP_LDI) && (op != OP_HALT);
    assign ID_OP                 = instr_q[31:27];
    assign ID_VD                 = instr_q[26:22];
    assign ID_VS                 = instr_q[21:17];
    assign ID_VT                 = instr_q[16:12];
    assign ID_SHAMT              = instr_q[11:0];
    assign ID_IMM16              = instr_q[15:0];
    assign register_mov_data     = mov_q;
    assign data_memory_direction = dmd_q;

endmodule

// File: tb/tb_vector_fetch_decode.sv
// Bench for vector_fetch_decode. A table gives each ROM word together with the
// outputs expected when it issues. Every fetch the DUT makes queues that
// address's record. Two negedges later the instruction is in ISSUE, and the
// record is popped and compared. Hand-written sequences cover stall hold,
// HALT/restart, pc wrap and reset during a stalled ISSUE.
module tb_vector_fetch_decode;

    typedef struct {
        logic [31:0] word;
        logic        valid;
        logic [31:0] mov;
        logic [31:0] dmd;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        vec_t       v;
    } sb_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stall;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  ID_OP, ID_VD, ID_VS, ID_VT;
    logic [11:0] ID_SHAMT;
    logic [15:0] ID_IMM16;
    logic [31:0] register_mov_data;
    logic [31:0] data_memory_direction;
    logic        ID_VALID, busy, halted;
    logic [7:0]  pc;

    vec_t tbl [256];
    sb_t  exp_q [$];
    logic f1, f2;
    int   tests = 0;
    int   fails = 0;

    vector_fetch_decode #(.PC_WIDTH(8), .NUM_SREGS(8)) dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ID_OP(ID_OP), .ID_VD(ID_VD), .ID_VS(ID_VS), .ID_VT(ID_VT),
        .ID_SHAMT(ID_SHAMT), .ID_IMM16(ID_IMM16),
        .register_mov_data(register_mov_data),
        .data_memory_direction(data_memory_direction),
        .ID_VALID(ID_VALID), .busy(busy), .halted(halted), .pc(pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction ROM: the data appears the cycle after the enable.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= tbl[imem_addr].word;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fields"}, {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT}, 32'h0);
        check({tag, " imm16"}, {16'h0, ID_IMM16}, 32'h0);
        check({tag, " mov"}, register_mov_data, 32'h0);
        check({tag, " dmd"}, data_memory_direction, 32'h0);
        check({tag, " flags"}, {28'h0, ID_VALID, imem_en, busy, halted}, 32'h0);
        check({tag, " pc"}, {24'h0, pc}, 32'h0);
    endtask

    task automatic wait_fetch(input logic [7:0] a, input int budget);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (imem_en === 1'b1 && imem_addr === a) found = 1'b1;
            else @(negedge clock);
        end
        check($sformatf("fetch_of_%0d", a), {31'h0, found}, 32'h1);
    endtask

    // Scoreboard monitor: push on fetch, pop and compare two negedges later, in ISSUE.
    always @(negedge clock) begin
        sb_t e;
        if (reset) begin
            f1 <= 1'b0;
            f2 <= 1'b0;
            exp_q.delete();
        end else begin
            if (f2) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'h0, 32'h1);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] issue pc=%0d word=%h valid=%0b mov=%h dmd=%h",
                             pc, e.v.word, ID_VALID, register_mov_data, data_memory_direction);
                    check($sformatf("pc@%0d", e.addr), {24'h0, pc}, {24'h0, e.addr});
                    check($sformatf("valid@%0d", e.addr), {31'h0, ID_VALID}, {31'h0, e.v.valid});
                    check($sformatf("fields@%0d", e.addr), {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT}, e.v.word);
                    check($sformatf("imm16@%0d", e.addr), {16'h0, ID_IMM16}, {16'h0, e.v.word[15:0]});
                    if (e.v.valid) begin
                        check($sformatf("mov@%0d", e.addr), register_mov_data, e.v.mov);
                        check($sformatf("dmd@%0d", e.addr), data_memory_direction, e.v.dmd);
                    end
                end
            end
            f2 <= f1;
            f1 <= imem_en;
            if (imem_en) exp_q.push_back('{addr: imem_addr, v: tbl[imem_addr]});
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 256; i++) tbl[i] = '{32'h0800_0000, 1'b1, 32'h0, 32'h0};
        tbl[0]   = '{32'hF040_0010, 1'b0, 32'h0,         32'h0};          // LDI s1 = 0x10
        tbl[1]   = '{32'h2802_FFFC, 1'b1, 32'h10,        32'h0C};         // op5 vs1 imm -4
        tbl[2]   = '{32'hF000_1234, 1'b0, 32'h0,         32'h0};          // LDI s0 (ignored)
        tbl[3]   = '{32'h0800_0008, 1'b1, 32'h0,         32'h8};          // MOV vs0
        tbl[4]   = '{32'hF080_8000, 1'b0, 32'h0,         32'h0};          // LDI s2 = -0x8000
        tbl[5]   = '{32'h1804_0001, 1'b1, 32'hFFFF_8000, 32'hFFFF_8001};  // op3 vs2 +1
        tbl[6]   = '{32'h1012_7FFF, 1'b1, 32'h10,        32'h800F};       // vs=9 -> s1
        tbl[7]   = '{32'hF240_FFFF, 1'b0, 32'h0,         32'h0};          // LDI vd=9 -> s1 = -1
        tbl[8]   = '{32'h2002_0001, 1'b1, 32'hFFFF_FFFF, 32'h0};          // -1 + 1 wraps
        tbl[9]   = '{32'hF800_0000, 1'b0, 32'h0,         32'h0};          // HALT
        tbl[255] = '{32'h3804_0010, 1'b1, 32'hFFFF_8000, 32'hFFFF_8010};

        // Reset state, then idle with no fetch before start.
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_no_fetch", {31'h0, imem_en}, 32'h0);

        // LDI then dependent op: the dependent op issues in cycle 6.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("c6_valid", {31'h0, ID_VALID}, 32'h1);
        check("c6_mov", register_mov_data, 32'h10);
        check("c6_dmd", data_memory_direction, 32'h0C);

        // Stall for four ISSUE cycles; a start pulse mid-stall must be ignored.
        wait_fetch(8'd5, 40);
        stall = 1'b1;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_valid", k), {31'h0, ID_VALID}, 32'h1);
            check($sformatf("stall%0d_pc", k), {24'h0, pc}, 32'd5);
            check($sformatf("stall%0d_mov", k), register_mov_data, 32'hFFFF_8000);
            check($sformatf("stall%0d_dmd", k), data_memory_direction, 32'hFFFF_8001);
            check($sformatf("stall%0d_en", k), {31'h0, imem_en}, 32'h0);
            start = (k == 1);
            if (k == 4) stall = 1'b0;
            @(negedge clock);
        end
        check("post_stall_en", {31'h0, imem_en}, 32'h1);
        check("post_stall_addr", {24'h0, imem_addr}, 32'd6);

        // HALT: state, pc held on the HALT word.
        for (int i = 0; i < 100 && !halted; i++) @(negedge clock);
        check("halted", {31'h0, halted}, 32'h1);
        check("halt_busy", {31'h0, busy}, 32'h0);
        check("halt_pc", {24'h0, pc}, 32'd9);
        repeat (3) @(negedge clock);
        check("halt_stays", {31'h0, halted, imem_en}, 32'h2);

        // Restart from HALT with the HALT word replaced, then run to pc 255 and wrap.
        tbl[9] = '{32'h0800_0000, 1'b1, 32'h0, 32'h0};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_fetch(8'd0, 4);
        wait_fetch(8'd255, 1000);
        repeat (3) @(negedge clock);
        check("wrap_en", {31'h0, imem_en}, 32'h1);
        check("wrap_addr", {24'h0, imem_addr}, 32'h0);

        // Reset while stalled in ISSUE.
        wait_fetch(8'd3, 40);
        stall = 1'b1;
        repeat (2) @(negedge clock);
        check("pre_reset_valid", {31'h0, ID_VALID}, 32'h1);
        @(posedge clock); #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        stall = 1'b0;
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        check_all_zero("after_reset");
        repeat (5) begin
            @(negedge clock);
            check("no_fetch_wo_start", {31'h0, imem_en}, 32'h0);
        end

        // Scalar registers must have been cleared: s1 read first thing reads zero.
        tbl[0] = '{32'h0802_0000, 1'b1, 32'h0, 32'h0};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_fetch(8'd0, 4);
        repeat (2) @(negedge clock);
        check("sreg_cleared", register_mov_data, 32'h0);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_fetch_decode.md
VECTOR_FETCH_DECODE -- requirements
Module: vector_fetch_decode

Interface
REQ-001 Parameter PC_WIDTH, default 8: instruction-memory address width.
REQ-002 Parameter NUM_SREGS, default 8: scalar registers; index = low log2(NUM_SREGS) bits of a field.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  pulse; begins fetching at PC 0 from IDLE or HALT.
REQ-006 stall  input  1  downstream vector processor not ready; holds issued instruction.
REQ-007 imem_en  output  1  instruction-memory read enable.
REQ-008 imem_addr  output  PC_WIDTH  instruction-memory address, equals pc.
REQ-009 imem_rdata  input  32  instruction word, valid the cycle after imem_en.
REQ-010 ID_OP 5, ID_VD 5, ID_VS 5, ID_VT 5, ID_SHAMT 12, ID_IMM16 16  outputs  decoded fields to vector processor.
REQ-011 register_mov_data  output  32  scalar register value for vector MOV.
REQ-012 data_memory_direction  output  32  load/store address to data memory.
REQ-013 ID_VALID  output  1  decoded outputs valid this cycle.
REQ-014 busy  output  1  high in FETCH, WAIT, ISSUE.
REQ-015 halted  output  1  high in HALT.
REQ-016 pc  output  PC_WIDTH  current program counter.

Function
REQ-017 Instruction format SHALL be op[31:27], vd[26:22], vs[21:17], vt[16:12], shamt[11:0], imm16[15:0] (imm16 overlaps vt/shamt).
REQ-018 FSM states SHALL be IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-019 IDLE: outputs idle; start=1 -> pc<=0, go FETCH.
REQ-020 FETCH: imem_en=1, imem_addr=pc, one cycle -> WAIT.
REQ-021 WAIT: imem_rdata latched into instruction register; all decoded outputs, register_mov_data and data_memory_direction registered on the same edge -> ISSUE.
REQ-022 register_mov_data SHALL be sreg[vs index]; data_memory_direction SHALL be sreg[vs index] + sign-extended imm16, modulo 2^32.
REQ-023 Scalar register 0 SHALL read as zero; writes to it ignored.
REQ-024 ISSUE, ordinary op: ID_VALID=1; stall=1 -> remain in ISSUE, all outputs held stable; stall=0 -> pc<=pc+1, go FETCH.
REQ-025 op 5'b11110 (LDI): sreg[vd index]<=sign-extended imm16 at the ISSUE edge; ID_VALID=0; stall ignored; pc<=pc+1, go FETCH.
REQ-026 op 5'b11111 (HALT): ID_VALID=0; pc unchanged; go HALT.
REQ-027 HALT: halted=1, busy=0; start=1 -> pc<=0, go FETCH; scalar registers retained.
REQ-028 start SHALL be ignored in FETCH, WAIT, ISSUE.
REQ-029 pc SHALL wrap from 2^PC_WIDTH-1 to 0 without halting.
REQ-030 Throughput SHALL be 3 cycles per instruction without stall; LDI result is visible to the immediately following instruction without forwarding.
REQ-031 ID_VALID SHALL be asserted only in ISSUE for non-LDI, non-HALT ops.

Reset
REQ-032 reset=1 SHALL force IDLE, pc=0, all ID_* outputs, register_mov_data, data_memory_direction = 0, ID_VALID=0, imem_en=0, busy=0, halted=0, all scalar registers=0, at any time including mid-ISSUE with stall asserted.
REQ-033 After reset release, no fetch SHALL occur until start.

Verification
REQ-034 start; ROM[0]=LDI vd=1 imm=0x0010, ROM[1]=op 00101 vs=1 imm16=0xFFFC -> cycle 6 ISSUE: ID_VALID=1, register_mov_data=0x10, data_memory_direction=0x0C.
REQ-035 Ordinary op at ISSUE with stall=1 for 4 cycles -> ID_VALID and all outputs stable 5 cycles, pc advances only after stall drops.
REQ-036 ROM[2]=HALT -> halted=1, pc=2, ID_VALID never high for it; later start -> FETCH at pc 0.
REQ-037 pc=255 ordinary op, no stall -> next imem_addr=0.
REQ-038 reset pulsed during ISSUE with stall=1 -> next cycle IDLE, all outputs 0, sreg reads 0.
REQ-039 LDI vd=0 imm=0x1234 then MOV vs=0 -> register_mov_data=0.
